if_id_stage: RTL
================

# if_id_stage

Front end of the five-stage RISC-V pipeline: owns the program counter, drives the instruction-memory fetch address, and holds the IF/ID pipeline register that feeds the decoder. It also detects load-use hazards and generates the `Stall` that freezes PC and IF/ID and makes the ID/EX register insert a bubble. Branch/jump redirects resolved in ID enter here; the wrong-path fetch is flushed to a NOP.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): instruction written into IF/ID on flush or bubble.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  32  fetch address, equal to the current PC.
- `imem_rdata`  in  32  instruction at `imem_addr`, valid the same cycle when `imem_ready`=1.
- `imem_ready`  in  1  fetch completes this cycle.
- `JumpFlag_id`  in  1  taken branch/jump resolved in ID this cycle.
- `JumpAddr_id`  in  32  redirect target, bits [1:0] ignored (forced 0).
- `MemRead_ex`  in  1  instruction in EX is a load.
- `rdAddr_ex`  in  5  destination of the instruction in EX.
- `rs1Addr_id`, `rs2Addr_id`  in  5 each  sources decoded from `Instruction_id`.
- `PC_id`  out  32  PC of the instruction in IF/ID.
- `Instruction_id`  out  32  instruction in IF/ID.
- `Valid_id`  out  1  IF/ID holds a real fetched instruction (0 for NOP bubbles).
- `Stall`  out  1  load-use hazard; to ID/EX `Stall` input.
- `StallCnt`, `FlushCnt`  out  32 each  performance counters (see Configuration).

## Operation
- Hazard: `Stall = MemRead_ex & (rdAddr_ex != 0) & ((rdAddr_ex == rs1Addr_id) | (rdAddr_ex == rs2Addr_id)) & Valid_id`. Combinational.
- Per-cycle priority, highest first:
  1. `Stall`=1: PC and IF/ID hold. `JumpFlag_id` is ignored because the jump re-resolves after the stall.
  2. `JumpFlag_id`=1: PC ← `{JumpAddr_id[31:2],2'b00}`. IF/ID ← {`NOP_INSTR`, PC_id unchanged, Valid 0}. This applies regardless of `imem_ready`. `FlushCnt`++.
  3. `imem_ready`=1: PC ← PC+4 (32-bit wrap, FFFF_FFFC→0). IF/ID ← {`imem_rdata`, PC, Valid 1}.
  4. `imem_ready`=0: PC holds. IF/ID ← {`NOP_INSTR`, PC_id unchanged, Valid 0} (fetch bubble).
- `StallCnt` increments in every cycle with `Stall`=1.
- Both counters saturate at FFFF_FFFF.

## Timing
- Reset values (async assert, sync-safe deassert): PC=`RESET_PC`, `imem_addr`=`RESET_PC`, `PC_id`=0, `Instruction_id`=`NOP_INSTR`, `Valid_id`=0, counters 0.
- `Stall` is asserted only as a function of current inputs, so it is 0 while `rst_n`=0.
- Fetch-to-ID latency is 1 cycle: an instruction accepted at edge N is on `Instruction_id` after edge N.
- A load-use stall lasts exactly 1 cycle. The load leaves EX at the stall edge, ID/EX captures a bubble, and `Stall` drops next cycle.
- Redirect penalty is 1 cycle: one flushed slot, and the target is fetched the cycle after `JumpFlag_id`.
- Reset mid-stall or mid-redirect discards all pending state and restarts fetch at `RESET_PC`.

## Configuration
- `IFID_PERF_CNT_EN` defined: `StallCnt` and `FlushCnt` count as described.
- `IFID_PERF_CNT_EN` undefined: no counter flops are built and both ports are driven constant 0. All other behaviour is identical.

## Structure
- Shared package `riscv_pkg`: `NOP_INSTR` constant, `XLEN`=32, `REG_ADDR_W`=5, and the default reset vector.
- One sub-module, `hazard_detect`, purely combinational, computes `Stall` from the EX/ID fields. Everything else lives in `if_id_stage`.

## Test plan
- Reset then `imem_ready`=1 with rdata sequence A,B,C → `imem_addr` is 0,4,8. `Instruction_id` is A,B,C one cycle later with `Valid_id`=1 and `PC_id` 0,4,8.
- `MemRead_ex`=1, `rdAddr_ex`=5, `rs1Addr_id`=5 → `Stall`=1 for one cycle and PC/IF/ID hold. With `rdAddr_ex`=0 → `Stall`=0.
- `JumpFlag_id`=1, `JumpAddr_id`=0x103 with `imem_ready`=0 → next PC=0x100, `Instruction_id`=0x00000013, `Valid_id`=0, `FlushCnt`=1.
- `Stall` and `JumpFlag_id` in the same cycle → PC unchanged, no flush, `StallCnt`=1, `FlushCnt`=0.
- `imem_ready` low for 3 cycles → PC holds and three NOP bubbles appear with `Valid_id`=0. PC at FFFF_FFFC with ready → wraps to 0.
- Assert `rst_n`=0 mid-stall → outputs take reset values immediately, and fetch resumes at `RESET_PC` after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline front end: data widths,
// the canonical NOP encoding, the default reset vector and a small
// helper that word-aligns a fetch address.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction fetches are always word aligned; the low two bits of any
  // redirect target are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector. Purely combinational: raises stall when the
// load in EX writes a non-zero register that the valid instruction in ID
// reads through either source operand.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic                  mem_read_ex,
  input  logic [REG_ADDR_W-1:0] rd_addr_ex,
  input  logic [REG_ADDR_W-1:0] rs1_addr_id,
  input  logic [REG_ADDR_W-1:0] rs2_addr_id,
  input  logic                  valid_id,
  output logic                  stall
);

  logic rd_nonzero;
  logic src_match;

  // Compare the load destination against both ID source operands.
  always_comb begin
    rd_nonzero = (rd_addr_ex != '0);
    src_match  = (rd_addr_ex == rs1_addr_id) | (rd_addr_ex == rs2_addr_id);
    stall      = mem_read_ex & rd_nonzero & src_match & valid_id;
  end

endmodule

// File: rtl/if_id_stage.sv
// Pipeline front end: program counter, instruction fetch address and the
// IF/ID pipeline register, plus load-use stall generation.
//
// Optional build macro IFID_PERF_CNT_EN: when defined, StallCnt and
// FlushCnt are saturating 32-bit counters; when undefined no counter
// flops exist and both ports read 0.
//
// Fetch handshake: imem_addr always presents the current PC; a fetch is
// accepted on a rising edge where imem_ready=1, at which point imem_rdata
// is the instruction at imem_addr. While the stage is stalled or being
// redirected, a ready fetch is simply not consumed and is refetched later.
module if_id_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        JumpFlag_id,
  input  logic [31:0] JumpAddr_id,
  input  logic        MemRead_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic [4:0]  rs1Addr_id,
  input  logic [4:0]  rs2Addr_id,
  output logic [31:0] PC_id,
  output logic [31:0] Instruction_id,
  output logic        Valid_id,
  output logic        Stall,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic        valid_id_q, valid_id_d;
  logic        flush;

  hazard_detect u_hazard_detect (
    .mem_read_ex (MemRead_ex),
    .rd_addr_ex  (rdAddr_ex),
    .rs1_addr_id (rs1Addr_id),
    .rs2_addr_id (rs2Addr_id),
    .valid_id    (valid_id_q),
    .stall       (Stall)
  );

  // Next-state selection for PC and IF/ID: stall, then redirect, then
  // fetch accept, otherwise a fetch bubble.
  always_comb begin
    pc_d       = pc_q;
    pc_id_d    = pc_id_q;
    instr_id_d = instr_id_q;
    valid_id_d = valid_id_q;
    flush      = 1'b0;
    if (Stall) begin
      // Hold everything; any jump in ID re-resolves after the stall.
    end else if (JumpFlag_id) begin
      pc_d       = word_align(JumpAddr_id);
      instr_id_d = NOP_INSTR;
      valid_id_d = 1'b0;
      flush      = 1'b1;
    end else if (imem_ready) begin
      pc_d       = pc_q + 32'd4;
      pc_id_d    = pc_q;
      instr_id_d = imem_rdata;
      valid_id_d = 1'b1;
    end else begin
      instr_id_d = NOP_INSTR;
      valid_id_d = 1'b0;
    end
  end

  // PC and IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      pc_id_q    <= '0;
      instr_id_q <= NOP_INSTR;
      valid_id_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_id_q    <= pc_id_d;
      instr_id_q <= instr_id_d;
      valid_id_q <= valid_id_d;
    end
  end

  assign imem_addr      = pc_q;
  assign PC_id          = pc_id_q;
  assign Instruction_id = instr_id_q;
  assign Valid_id       = valid_id_q;

`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters for stall cycles and redirect flushes.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign StallCnt     = '0;
  assign FlushCnt     = '0;
`endif

endmodule
